// File: rtl/cache_ctrl_pkg.sv
// Shared types for the 4-way cache controller: way index, FSM states and
// the one-hot way-select helper.
package cache_ctrl_pkg;

    localparam int WAYS = 4;

    typedef logic [1:0] way_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        WTHRU,
        RESP
    } state_t;

    function automatic logic [WAYS-1:0] onehot4(way_idx_t w);
        onehot4 = 4'b0001 << w;
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag/round-robin state for every set: combinational lookup plus a
// synchronous fill port that installs a tag and advances the replacement pointer.
module cache_tag_store
    import cache_ctrl_pkg::*;
#(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 6
) (
    input  logic               clk,
    input  logic               gen_reset,
    input  logic [INDEX_W-1:0] i_index,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_hit,
    output way_idx_t           o_hit_way,
    output way_idx_t           o_victim,
    input  logic               i_fill_en,
    input  way_idx_t           i_fill_way
);

    localparam int SETS = 1 << INDEX_W;

    logic [WAYS-1:0]  r_valid [SETS];
    logic [TAG_W-1:0] r_tag   [WAYS][SETS];
    way_idx_t         r_rr    [SETS];

    logic [WAYS-1:0]  w_set_valid;

    assign w_set_valid = r_valid[i_index];

    // Descending scans so the lowest-indexed way is the last one written.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_way = '0;
        o_victim  = r_rr[i_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_set_valid[w] && (r_tag[w][i_index] == i_tag)) begin
                o_hit     = 1'b1;
                o_hit_way = way_idx_t'(w);
            end
            if (!w_set_valid[w]) begin
                o_victim = way_idx_t'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!gen_reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (i_fill_en) begin
            r_valid[i_index][i_fill_way] <= 1'b1;
            r_tag[i_fill_way][i_index]   <= i_tag;
            if (&w_set_valid) begin
                r_rr[i_index] <= r_rr[i_index] + 2'd1;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// 4-way set-associative cache controller with write-through, no write-allocate.
// Hit/miss statistics counters are built only when CACHE_STATS_EN is defined.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 10,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               gen_reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_busy,
    output logic               cpu_ack,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic [INDEX_W-1:0] arr_addr,
    output logic               arr_re,
    output logic [3:0]         arr_we,
    output logic [DATA_W-1:0]  arr_wdata,
    input  logic [DATA_W-1:0]  arr_rdata0,
    input  logic [DATA_W-1:0]  arr_rdata1,
    input  logic [DATA_W-1:0]  arr_rdata2,
    input  logic [DATA_W-1:0]  arr_rdata3,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_t             r_state;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_cpu_ack;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    way_idx_t           w_hit_way;
    way_idx_t           w_victim;
    logic               w_accept;
    logic               w_fill;
    logic               w_store_hit;
    logic [DATA_W-1:0]  w_hit_rdata;

    assign w_index     = r_addr[INDEX_W-1:0];
    assign w_tag       = r_addr[ADDR_W-1:INDEX_W];
    assign w_accept    = gen_reset && (r_state == IDLE) && cpu_req;
    assign w_fill      = (r_state == MISS) && mem_ack;
    assign w_store_hit = (r_state == LOOKUP) && r_we && w_hit;

    cache_tag_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tags (
        .clk        (clk),
        .gen_reset  (gen_reset),
        .i_index    (w_index),
        .i_tag      (w_tag),
        .o_hit      (w_hit),
        .o_hit_way  (w_hit_way),
        .o_victim   (w_victim),
        .i_fill_en  (w_fill),
        .i_fill_way (w_victim)
    );

    always_comb begin
        case (w_hit_way)
            2'd0:    w_hit_rdata = arr_rdata0;
            2'd1:    w_hit_rdata = arr_rdata1;
            2'd2:    w_hit_rdata = arr_rdata2;
            default: w_hit_rdata = arr_rdata3;
        endcase
    end

    // The arrays are synchronous RAMs, so address/enables must be presented
    // combinationally in the cycle before the data is needed or written.
    assign arr_re    = w_accept;
    assign arr_addr  = w_accept ? cpu_addr[INDEX_W-1:0] : w_index;
    assign arr_we    = w_store_hit ? onehot4(w_hit_way) :
                       w_fill      ? onehot4(w_victim)  : 4'b0000;
    assign arr_wdata = (r_state == MISS) ? mem_rdata : r_wdata;

    assign cpu_busy  = (r_state != IDLE);
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (!gen_reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit && !r_we) begin
                        r_cpu_rdata <= w_hit_rdata;
                        r_cpu_ack   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= r_we;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= r_we ? WTHRU : MISS;
                    end
                end
                MISS: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_cpu_rdata <= mem_rdata;
                        r_cpu_ack   <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WTHRU: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_cpu_ack <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (!gen_reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            end else begin
                if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule
